// File: rtl/ysyx_2022040010_icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: default geometry,
// FSM encodings, address field widths and the word-select helper.
package ysyx_2022040010_icache_pkg;

  localparam int ICACHE_LINES_DEFAULT = 64;

  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_MISS = 1'b1;

  localparam int ICACHE_ADDR_W   = 64;
  localparam int ICACHE_PADDR_W  = 32;
  localparam int ICACHE_OFFSET_W = 3;
  localparam int ICACHE_INST_W   = 32;
  localparam int ICACHE_LINE_W   = 64;
  // Line address = physical address without the byte offset.
  localparam int ICACHE_LADDR_W  = ICACHE_PADDR_W - ICACHE_OFFSET_W;

  function automatic logic [ICACHE_INST_W-1:0] icache_sel_word(
    input logic [ICACHE_LINE_W-1:0] line,
    input logic                     hi
  );
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ysyx_2022040010_icache_array.sv
// Valid/tag/data storage for the icache: combinational read port, one write
// port and a global valid clear that takes effect before a same-edge write.
module ysyx_2022040010_icache_array
  import ysyx_2022040010_icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEFAULT,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ICACHE_LADDR_W - IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic                     rd_valid_o,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic [ICACHE_LINE_W-1:0] rd_data_o,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [TAG_W-1:0]         wr_tag_i,
  input  logic [ICACHE_LINE_W-1:0] wr_data_i,
  input  logic                     clr_i
);

  logic [LINES-1:0]                    valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]         tag_q, tag_d;
  logic [LINES-1:0][ICACHE_LINE_W-1:0] data_q, data_d;

  // NOTE: every always_comb target gets a full default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = '0;
    end
    if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
      tag_d[wr_idx_i]   = wr_tag_i;
      data_d[wr_idx_i]  = wr_data_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: tag and data storage is deliberately not reset; the valid bits gate
  // every use of it, and leaving it unreset keeps it mappable to plain flops.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/ysyx_2022040010_icache.sv
// Direct-mapped read-only instruction cache with a single 64-bit line refill
// through the arbiter handshake. Define ICACHE_PERF_EN for hit/miss counters.
module ysyx_2022040010_icache
  import ysyx_2022040010_icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     isram_e_i,
  input  logic [ICACHE_ADDR_W-1:0] isram_addr_i,
  input  logic                     fence_i_i,
  output logic [ICACHE_INST_W-1:0] inst_o,
  output logic                     inst_valid_o,
  output logic                     stallreq_o,
  output logic                     icache_re_o,
  output logic [ICACHE_ADDR_W-1:0] icache_addr_o,
  input  logic [ICACHE_LINE_W-1:0] icache_data_i,
  input  logic                     icache_refresh_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [63:0]              hit_cnt_o,
  output logic [63:0]              miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ICACHE_LADDR_W - IDX_W;

  logic [0:0]                state_q, state_d;
  logic [ICACHE_LADDR_W-1:0] laddr_q, laddr_d;

  logic [IDX_W-1:0]         fetch_idx;
  logic [TAG_W-1:0]         fetch_tag;
  logic                     rd_valid;
  logic [TAG_W-1:0]         rd_tag;
  logic [ICACHE_LINE_W-1:0] rd_data;
  logic                     in_idle;
  logic                     in_miss;
  logic                     hit;
  logic                     miss_start;
  logic                     refill_we;
  logic                     unused_addr;

  assign fetch_idx = isram_addr_i[IDX_W+2:3];
  assign fetch_tag = isram_addr_i[31:IDX_W+3];
  // Upper half of the PC and the always-zero byte bits take no part in lookup.
  assign unused_addr = ^{isram_addr_i[63:32], isram_addr_i[1:0]};

  assign in_idle    = (state_q == ICACHE_IDLE);
  assign in_miss    = (state_q == ICACHE_MISS);
  assign hit        = isram_e_i & in_idle & rd_valid & (rd_tag == fetch_tag);
  assign miss_start = isram_e_i & in_idle & ~hit;
  assign refill_we  = in_miss & icache_refresh_i;

  ysyx_2022040010_icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (fetch_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (refill_we),
    .wr_idx_i   (laddr_q[IDX_W-1:0]),
    .wr_tag_i   (laddr_q[ICACHE_LADDR_W-1:IDX_W]),
    .wr_data_i  (icache_data_i),
    .clr_i      (fence_i_i)
  );

  // The latched line address is frozen for the whole MISS so the arbiter sees
  // a stable request even if fetch redirects its PC meanwhile.
  always_comb begin
    state_d = state_q;
    laddr_d = laddr_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (miss_start) begin
          state_d = ICACHE_MISS;
          laddr_d = isram_addr_i[31:3];
        end
      end
      default: begin
        if (icache_refresh_i) begin
          state_d = ICACHE_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ICACHE_IDLE;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      laddr_q <= laddr_d;
    end
  end

  assign inst_valid_o  = hit;
  assign inst_o        = hit ? icache_sel_word(rd_data, isram_addr_i[2]) : '0;
  assign stallreq_o    = miss_start | in_miss;
  assign icache_re_o   = in_miss;
  assign icache_addr_o = in_miss ? {32'b0, laddr_q, 3'b0} : '0;

`ifdef ICACHE_PERF_EN
  logic [63:0] hit_cnt_q, hit_cnt_d;
  logic [63:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {63'b0, hit};
    miss_cnt_d = miss_cnt_q + {63'b0, miss_start};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_icache.sv
// Self-checking bench for ysyx_2022040010_icache: directed scenarios followed
// by random fetch/fence/refill traffic against a line-address cache model.
module tb_ysyx_2022040010_icache;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        isram_e_i;
  logic [63:0] isram_addr_i;
  logic        fence_i_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        icache_re_o;
  logic [63:0] icache_addr_o;
  logic [63:0] icache_data_i;
  logic        icache_refresh_i;
`ifdef ICACHE_PERF_EN
  logic [63:0] hit_cnt_o;
  logic [63:0] miss_cnt_o;
`endif

  always #5 clk = ~clk;

  ysyx_2022040010_icache #(.LINES(LINES)) dut (
    .clk              (clk),
    .rst              (rst),
    .isram_e_i        (isram_e_i),
    .isram_addr_i     (isram_addr_i),
    .fence_i_i        (fence_i_i),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o),
    .stallreq_o       (stallreq_o),
    .icache_re_o      (icache_re_o),
    .icache_addr_o    (icache_addr_o),
    .icache_data_i    (icache_data_i),
    .icache_refresh_i (icache_refresh_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the full line address it holds.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  logic [63:0] m_data  [LINES];
  bit          m_miss;
  logic [31:0] m_pending;
  longint unsigned m_hits, m_misses;

  // Inputs applied during the current cycle.
  bit          s_e, s_fence, s_ref;
  logic [63:0] s_pc, s_data;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 3) % LINES);
  endfunction

  function automatic bit model_hit(input bit e, input logic [63:0] pc);
    int k;
    k = idx_of(pc[31:0]);
    return e && !m_miss && m_valid[k] && (m_line[k] == (pc[31:0] & ~32'h7));
  endfunction

  function automatic logic [63:0] line_data(input logic [31:0] la);
    return {la ^ 32'hA5A5_0F0F, ~la};
  endfunction

  task automatic model_reset();
    foreach (m_valid[k]) m_valid[k] = 1'b0;
    m_miss = 1'b0; m_pending = '0; m_hits = 0; m_misses = 0;
    s_e = 1'b0; s_fence = 1'b0; s_ref = 1'b0; s_pc = '0; s_data = '0;
  endtask

  task automatic model_edge();
    bit h;
    int k;
    h = model_hit(s_e, s_pc);
    if (h) m_hits++;
    if (s_fence) foreach (m_valid[j]) m_valid[j] = 1'b0;
    if (m_miss) begin
      if (s_ref) begin
        k = idx_of(m_pending);
        m_valid[k] = 1'b1;
        m_line[k]  = m_pending;
        m_data[k]  = s_data;
        m_miss     = 1'b0;
      end
    end else if (s_e && !h) begin
      m_miss    = 1'b1;
      m_pending = s_pc[31:0] & ~32'h7;
      m_misses++;
    end
  endtask

  task automatic check_model();
    bit h;
    logic [63:0] line;
    logic [31:0] exp_inst;
    h = model_hit(s_e, s_pc);
    line = m_data[idx_of(s_pc[31:0])];
    exp_inst = h ? (s_pc[2] ? line[63:32] : line[31:0]) : 32'h0;
    check("inst_valid", 64'(inst_valid_o), 64'(h));
    check("inst", 64'(inst_o), 64'(exp_inst));
    check("stall", 64'(stallreq_o), 64'((s_e && !h) || m_miss));
    check("re", 64'(icache_re_o), 64'(m_miss));
    check("raddr", icache_addr_o, m_miss ? {32'b0, m_pending} : 64'b0);
`ifdef ICACHE_PERF_EN
    check("hit_cnt", hit_cnt_o, m_hits);
    check("miss_cnt", miss_cnt_o, m_misses);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply(input bit e, input logic [63:0] pc, input bit fence,
                       input bit refresh, input logic [63:0] data);
    isram_e_i = e; isram_addr_i = pc; fence_i_i = fence;
    icache_refresh_i = refresh; icache_data_i = data;
    s_e = e; s_pc = pc; s_fence = fence; s_ref = refresh; s_data = data;
    @(negedge clk);
    check_model();
  endtask

  task automatic step(input bit e, input logic [63:0] pc, input bit fence,
                      input bit refresh, input logic [63:0] data);
    advance();
    apply(e, pc, fence, refresh, data);
  endtask

  // Miss on pc, wait `delay` cycles in MISS, refill with data, then re-hit.
  task automatic fill(input logic [63:0] pc, input int delay, input logic [63:0] data);
    step(1'b1, pc, 1'b0, 1'b0, '0);
    check("fill_stall", 64'(stallreq_o), 64'd1);
    for (int i = 0; i < delay; i++) begin
      step(1'b1, pc, 1'b0, 1'b0, '0);
      check("fill_re", 64'(icache_re_o), 64'd1);
      check("fill_addr", icache_addr_o, {32'b0, pc[31:3], 3'b0});
    end
    step(1'b1, pc, 1'b0, 1'b1, data);
    step(1'b1, pc, 1'b0, 1'b0, '0);
    check("fill_hit", 64'(inst_valid_o), 64'd1);
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] data;
    bit          e, fence, refresh;
    int          wait_cnt;

    rst = 1'b0;
    isram_e_i = 1'b0; isram_addr_i = '0; fence_i_i = 1'b0;
    icache_data_i = '0; icache_refresh_i = 1'b0;
    model_reset();
    #12;
    check("rst_re", 64'(icache_re_o), 64'd0);
    check("rst_raddr", icache_addr_o, 64'd0);
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss with a 3-cycle arbiter.
    fill(64'h8000_0000, 3, 64'h0000_0093_0000_0013);
    check("cold_inst0", 64'(inst_o), 64'h13);
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0, '0);
    check("cold_inst1", 64'(inst_o), 64'h93);
    check("cold_valid1", 64'(inst_valid_o), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, '0);
`ifdef ICACHE_PERF_EN
    check("perf_hits", hit_cnt_o, 64'd2);
    check("perf_misses", miss_cnt_o, 64'd1);
`endif

    // Conflict on index 0.
    fill(64'h8000_0200, 2, line_data(32'h8000_0200));
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0);
    check("conflict_remiss", 64'(inst_valid_o), 64'd0);
    check("conflict_stall", 64'(stallreq_o), 64'd1);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b1, line_data(32'h8000_0000));
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0);
    check("conflict_refill_hit", 64'(inst_valid_o), 64'd1);

    // Fence while hitting.
    step(1'b1, 64'h8000_0000, 1'b1, 1'b0, '0);
    check("fence_hit_same_cycle", 64'(inst_valid_o), 64'd1);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0);
    check("fence_miss", 64'(inst_valid_o), 64'd0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0);
    check("fence_re", 64'(icache_re_o), 64'd1);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b1, line_data(32'h8000_0000));

    // PC redirect during MISS.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);
      check("redir_addr0", icache_addr_o, 64'h8000_0000);
    end
    step(1'b1, 64'h8000_1000, 1'b0, 1'b1, line_data(32'h8000_0000));
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);
    check("redir_second_miss", 64'(stallreq_o), 64'd1);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);
    check("redir_addr1", icache_addr_o, 64'h8000_1000);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b1, line_data(32'h8000_1000));
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);
    check("redir_hit_inst", 64'(inst_o), 64'(line_data(32'h8000_1000) & 64'hFFFF_FFFF));

    // Reset asserted while in MISS.
    step(1'b1, 64'h8000_0100, 1'b0, 1'b0, '0);
    step(1'b1, 64'h8000_0100, 1'b0, 1'b0, '0);
    check("pre_rst_re", 64'(icache_re_o), 64'd1);
    #2;
    rst = 1'b0;
    isram_e_i = 1'b0;
    #1;
    check("async_rst_re", 64'(icache_re_o), 64'd0);
    check("async_rst_raddr", icache_addr_o, 64'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);
    check("post_rst_miss", 64'(inst_valid_o), 64'd0);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b1, line_data(32'h8000_1000));
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0);

    // Random traffic with a model-driven arbiter.
    wait_cnt = 0;
    pc = 64'h8000_0000;
    for (int c = 0; c < 3000; c++) begin
      advance();
      refresh = 1'b0;
      if (m_miss) begin
        if (wait_cnt == 0) refresh = 1'b1;
        else wait_cnt--;
      end else begin
        refresh  = ($urandom_range(0, 49) == 0);
        wait_cnt = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 1) == 0)
        pc = {$urandom(), 32'h8000_0000 | (32'($urandom_range(0, 511)) << 2)};
      e     = ($urandom_range(0, 9) != 0);
      fence = ($urandom_range(0, 39) == 0);
      data  = (refresh && m_miss) ? line_data(m_pending) : {$urandom(), $urandom()};
      apply(e, pc, fence, refresh, data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
